// File: rtl/controle_magnetron.sv
// controle_magnetron: magnetron enable interlock for the microwave oven.
// Synchronizes all panel/sensor inputs, debounces the three buttons, and runs a
// two-state cooking FSM whose registered output enables magnetron power.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   startn       start button, active-low, asynchronous
//   stopn        stop button, active-low, asynchronous
//   clearn       clear button, active-low, asynchronous (same effect as stop)
//   door_closed  1 = door closed, asynchronous
//   timer_done   1 = cook timer expired, asynchronous
//   mag_on       magnetron enable, registered, high only while cooking
module controle_magnetron #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic startn,
  input  logic stopn,
  input  logic clearn,
  input  logic door_closed,
  input  logic timer_done,
  output logic mag_on
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  // Bit order: {timer_done, door_closed, clearn, stopn, startn}.
  // Inactive levels: buttons released (1), door open (0), timer not done (0).
  localparam logic [4:0] InactiveLvl = 5'b00111;

  typedef enum logic {StIdle, StCooking} state_e;

  logic [4:0]                    raw_in;
  logic [SYNC_STAGES-1:0][4:0]   sync_q;
  logic [4:0]                    synced;
  logic [2:0]                    filt_q, filt_d;
  logic [2:0][CntW-1:0]          cnt_q, cnt_d;
  logic                          start_prev_q;
  logic                          start_pulse;
  logic                          stop_cond;
  state_e                        state_q;
  logic                          mag_on_q;

  assign raw_in = {timer_done, door_closed, clearn, stopn, startn};

  // Synchronizer chain: stage 0 samples the pins, last stage feeds the logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{InactiveLvl}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Debounce the three buttons: the filtered level flips only after the synced
  // level has disagreed with it for DEBOUNCE_CYCLES consecutive cycles. Any
  // agreement restarts the count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    for (int b = 0; b < 3; b++) begin
      if (synced[b] != filt_q[b]) begin
        if (cnt_q[b] == CntMax) begin
          filt_d[b] = synced[b];
        end else begin
          cnt_d[b] = cnt_q[b] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q       <= 3'b111;
      cnt_q        <= '0;
      start_prev_q <= 1'b1;
    end else begin
      filt_q       <= filt_d;
      cnt_q        <= cnt_d;
      start_prev_q <= filt_q[0];
    end
  end

  // One-cycle request on the falling edge of filtered startn; holding the
  // button never produces another.
  assign start_pulse = start_prev_q & ~filt_q[0];

  // Door and timer bypass the debouncer so the safety path stays fast.
  assign stop_cond = ~filt_q[1] | ~filt_q[2] | ~synced[3] | synced[4];

  // Cooking FSM. stop_cond wins over a simultaneous start; a discarded start
  // is not remembered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      mag_on_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_pulse && !stop_cond) begin
            state_q  <= StCooking;
            mag_on_q <= 1'b1;
          end
        end
        StCooking: begin
          if (stop_cond) begin
            state_q  <= StIdle;
            mag_on_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= StIdle;
          mag_on_q <= 1'b0;
        end
      endcase
    end
  end

  assign mag_on = mag_on_q;

endmodule

// File: tb/tb_controle_magnetron.sv
module tb_controle_magnetron;

  localparam int S = 2;
  localparam int D = 4;
  // Bit order: {timer_done, door_closed, clearn, stopn, startn}
  localparam logic [4:0] Inact = 5'b00111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic startn = 1'b1;
  logic stopn = 1'b1;
  logic clearn = 1'b1;
  logic door_closed = 1'b0;
  logic timer_done = 1'b0;
  logic mag_on;

  always #5 clk = ~clk;

  controle_magnetron #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .startn     (startn),
    .stopn      (stopn),
    .clearn     (clearn),
    .door_closed(door_closed),
    .timer_done (timer_done),
    .mag_on     (mag_on)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: history of pin samples per clock edge since reset release.
  logic [4:0] raw_q[$];
  logic [4:0] syn_q[$];
  logic [2:0] f_cur, f_prev;
  logic       m_cook;
  logic [4:0] cur_in;

  function automatic logic [4:0] syn_at(int k);
    if (k < 0 || k >= syn_q.size()) return Inact;
    return syn_q[k];
  endfunction

  task automatic model_reset();
    raw_q.delete();
    syn_q.delete();
    f_cur  = 3'b111;
    f_prev = 3'b111;
    m_cook = 1'b0;
  endtask

  // One rising edge of the spec-level behaviour, using only values visible
  // before the edge.
  task automatic model_edge(input logic [4:0] raw);
    int         n;
    logic [4:0] sp;
    logic [4:0] w;
    logic [2:0] f_new;
    logic       stop, pulse, all_diff;
    n     = syn_q.size();
    sp    = syn_at(n - 1);
    stop  = !f_cur[1] || !f_cur[2] || !sp[3] || sp[4];
    pulse = f_prev[0] && !f_cur[0];
    if (m_cook && stop) m_cook = 1'b0;
    else if (!m_cook && pulse && !stop) m_cook = 1'b1;
    f_new = f_cur;
    for (int b = 0; b < 3; b++) begin
      all_diff = 1'b1;
      for (int j = 1; j <= D; j++) begin
        w = syn_at(n - j);
        if (w[b] == f_cur[b]) all_diff = 1'b0;
      end
      if (all_diff) f_new[b] = ~f_cur[b];
    end
    f_prev = f_cur;
    f_cur  = f_new;
    raw_q.push_back(raw);
    if (n - S + 1 >= 0) syn_q.push_back(raw_q[n-S+1]);
    else syn_q.push_back(Inact);
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: mag_on=%0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] v);
    {timer_done, door_closed, clearn, stopn, startn} = v;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic tick(input string tag);
    drive(cur_in);
    @(posedge clk);
    model_edge(cur_in);
    #1;
    check(tag, mag_on, m_cook);
    @(negedge clk);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    cur_in = Inact;
    drive(cur_in);
    model_reset();
    #12;
    check("reset_state", mag_on, 1'b0);
    @(negedge clk);
    cur_in = 5'b01111;
    drive(cur_in);
    reset = 1'b0;

    // Idle with door closed, no press.
    run(20, "idle_no_press");
    check("idle_const", mag_on, 1'b0);

    // Start press: rises on the 7th edge.
    cur_in = 5'b01110;
    for (int i = 1; i <= 10; i++) begin
      tick("start_press");
      if (i == 6) check("start_lat_6", mag_on, 1'b0);
      if (i == 7) check("start_lat_7", mag_on, 1'b1);
    end
    cur_in = 5'b01111;
    run(10, "start_release");
    check("cook_after_release", mag_on, 1'b1);

    // Door opens: falls on the 3rd edge.
    cur_in = 5'b00111;
    for (int i = 1; i <= 3; i++) begin
      tick("door_open");
      if (i == 2) check("door_lat_2", mag_on, 1'b1);
      if (i == 3) check("door_lat_3", mag_on, 1'b0);
    end
    cur_in = 5'b00110;
    run(10, "start_door_open");
    cur_in = 5'b01110;
    run(12, "door_close_held");
    check("door_close_held_const", mag_on, 1'b0);
    cur_in = 5'b01111;
    run(8, "release");
    cur_in = 5'b01110;
    for (int i = 1; i <= 7; i++) tick("restart");
    check("restart_7", mag_on, 1'b1);
    cur_in = 5'b01111;
    run(6, "restart_release");

    // Stop press: falls on the 7th edge; start while stop held ignored.
    cur_in = 5'b01101;
    for (int i = 1; i <= 7; i++) begin
      tick("stop_press");
      if (i == 6) check("stop_lat_6", mag_on, 1'b1);
      if (i == 7) check("stop_lat_7", mag_on, 1'b0);
    end
    cur_in = 5'b01100;
    run(12, "start_during_stop");
    check("start_during_stop_const", mag_on, 1'b0);
    cur_in = 5'b01111;
    run(8, "release");
    cur_in = 5'b01110;
    run(10, "start_again");
    cur_in = 5'b01111;
    run(4, "release");
    check("cook_before_clear", mag_on, 1'b1);

    // Clear press.
    cur_in = 5'b01011;
    for (int i = 1; i <= 7; i++) begin
      tick("clear_press");
      if (i == 6) check("clear_lat_6", mag_on, 1'b1);
    end
    check("clear_lat_7", mag_on, 1'b0);
    cur_in = 5'b01111;
    run(8, "release");

    // Timer expiry.
    cur_in = 5'b01110;
    run(10, "start_for_timer");
    cur_in = 5'b01111;
    run(4, "release");
    cur_in = 5'b11111;
    for (int i = 1; i <= 3; i++) tick("timer_done");
    check("timer_lat_3", mag_on, 1'b0);
    cur_in = 5'b11110;
    run(12, "start_timer_done");
    check("start_timer_done_const", mag_on, 1'b0);
    cur_in = 5'b01111;
    run(8, "release");

    // Short glitch on startn.
    cur_in = 5'b01110;
    run(2, "glitch");
    cur_in = 5'b01111;
    run(12, "glitch_after");
    check("glitch_const", mag_on, 1'b0);

    // Asynchronous reset while cooking.
    cur_in = 5'b01110;
    run(10, "start_for_reset");
    cur_in = 5'b01111;
    run(3, "release");
    check("cook_before_reset", mag_on, 1'b1);
    #2 reset = 1'b1;
    #1 check("async_reset_immediate", mag_on, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    run(12, "after_reset");
    check("after_reset_const", mag_on, 1'b0);

    // Randomized segments checked against the model every cycle.
    for (int seg = 0; seg < 80; seg++) begin
      cur_in[0] = ($urandom_range(0, 99) < 40) ? 1'b0 : 1'b1;
      cur_in[1] = ($urandom_range(0, 99) < 10) ? 1'b0 : 1'b1;
      cur_in[2] = ($urandom_range(0, 99) < 6)  ? 1'b0 : 1'b1;
      cur_in[3] = ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0;
      cur_in[4] = ($urandom_range(0, 99) < 8)  ? 1'b1 : 1'b0;
      run(int'($urandom_range(1, 12)), "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
